// File: rtl/tmds_serial_tx_if.sv
// tmds_serial_tx_if
// Pixel-stream bus feeding the TMDS serialiser.
//   pix_valid            : source has a pixel word
//   pix_ready            : one-cycle accept strobe from the serialiser
//   pix_r/pix_g/pix_b    : 8-bit colour components
//   pix_de               : 1 = active video, 0 = blanking/control period
//   pix_hsync/pix_vsync  : sync levels carried on the blue channel during blanking
// Modports: master = pixel source, slave = serialiser.
interface tmds_serial_tx_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_de;
  logic       pix_hsync;
  logic       pix_vsync;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b, pix_de, pix_hsync, pix_vsync,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b, pix_de, pix_hsync, pix_vsync,
    output pix_ready
  );
endinterface

// File: rtl/tmds_serial_tx.sv
// tmds_serial_tx
// DVI/TMDS transmitter running on the serial bit clock. Each 10-cycle symbol
// period one pixel is taken from the pixel bus, encoded (8b/10b data or
// control symbol) per channel and shifted out LSB first.
// Ports:
//   clk        : serial bit clock, one TMDS bit per channel per cycle
//   rst        : synchronous active-high reset
//   pix        : pixel bus (slave side), pix_ready pulses when bit_cnt == 9
//   tmds_d     : serial data, [0]=blue, [1]=green, [2]=red
//   tmds_clk   : serial TMDS clock channel (five ones, five zeros per symbol)
//   underflow  : sticky, set when a symbol slot passes without a valid pixel
module tmds_serial_tx #(
  parameter int CLK_PHASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  tmds_serial_tx_if.slave  pix,
  output logic [2:0]       tmds_d,
  output logic             tmds_clk,
  output logic             underflow
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = 10'b1101010100;
      2'b01:   sym = 10'b0010101011;
      2'b10:   sym = 10'b0101010100;
      default: sym = 10'b1010101011;
    endcase
    return sym;
  endfunction

  // Bit i of the pattern is the clock-channel level while bit_cnt == i.
  function automatic logic [9:0] clk_pattern(input int phase);
    logic [9:0] pat;
    for (int i = 0; i < 10; i++) begin
      pat[i] = (((i - phase + 10) % 10) < 5);
    end
    return pat;
  endfunction

  localparam logic [9:0] CLK_PATTERN = clk_pattern(CLK_PHASE);

  // DVI 1.0 data encoder. Returns {new_disparity[5:0], symbol[9:0]}.
  function automatic logic [15:0] tmds_encode(input logic [7:0] d,
                                              input logic signed [5:0] disp);
    logic [8:0]        q_m;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic signed [5:0] ones;
    logic signed [5:0] zeros;
    logic signed [5:0] new_disp;
    logic [9:0]        sym;

    n1d = '0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + {3'b000, d[i]};
    end
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

    q_m[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
    end
    q_m[8] = ~use_xnor;

    n1q = '0;
    for (int i = 0; i < 8; i++) begin
      n1q = n1q + {3'b000, q_m[i]};
    end
    ones  = $signed({2'b00, n1q});
    zeros = 6'sd8 - ones;

    if ((disp == 6'sd0) || (ones == zeros)) begin
      sym      = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      new_disp = q_m[8] ? (disp + ones - zeros) : (disp + zeros - ones);
    end else if (((disp > 6'sd0) && (ones > zeros)) ||
                 ((disp < 6'sd0) && (zeros > ones))) begin
      // Running disparity would grow: send inverted payload.
      sym      = {1'b1, q_m[8], ~q_m[7:0]};
      new_disp = disp + (q_m[8] ? 6'sd2 : 6'sd0) + zeros - ones;
    end else begin
      sym      = {1'b0, q_m[8], q_m[7:0]};
      new_disp = disp - (q_m[8] ? 6'sd0 : 6'sd2) + ones - zeros;
    end
    return {new_disp, sym};
  endfunction

  logic [3:0]        bit_cnt;
  logic [3:0]        cnt_nxt;
  logic              at_last;
  logic              ready_q;
  logic              underflow_nxt;
  logic [9:0]        sym_q    [3];
  logic [9:0]        sym_nxt  [3];
  logic signed [5:0] disp_q   [3];
  logic signed [5:0] disp_nxt [3];
  logic [15:0]       enc      [3];

  assign pix.pix_ready = ready_q;

  always_comb begin
    enc[0] = tmds_encode(pix.pix_b, disp_q[0]);
    enc[1] = tmds_encode(pix.pix_g, disp_q[1]);
    enc[2] = tmds_encode(pix.pix_r, disp_q[2]);
  end

  // A new symbol is loaded at every wrap of bit_cnt: a pixel if one is
  // offered, otherwise a blanking symbol that also flags underflow.
  always_comb begin
    at_last       = (bit_cnt == 4'd9);
    cnt_nxt       = at_last ? 4'd0 : bit_cnt + 4'd1;
    underflow_nxt = underflow;
    for (int ch = 0; ch < 3; ch++) begin
      sym_nxt[ch]  = sym_q[ch];
      disp_nxt[ch] = disp_q[ch];
    end
    if (at_last) begin
      if (!pix.pix_valid) begin
        for (int ch = 0; ch < 3; ch++) begin
          sym_nxt[ch]  = CTRL_00;
          disp_nxt[ch] = 6'sd0;
        end
        underflow_nxt = 1'b1;
      end else if (!pix.pix_de) begin
        sym_nxt[0] = ctrl_symbol({pix.pix_vsync, pix.pix_hsync});
        sym_nxt[1] = CTRL_00;
        sym_nxt[2] = CTRL_00;
        for (int ch = 0; ch < 3; ch++) begin
          disp_nxt[ch] = 6'sd0;
        end
      end else begin
        for (int ch = 0; ch < 3; ch++) begin
          {disp_nxt[ch], sym_nxt[ch]} = enc[ch];
        end
      end
    end
  end

  // Outputs are registered from the next-state values so that tmds_d,
  // tmds_clk and pix_ready always describe the bit position held in bit_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      underflow <= 1'b0;
      ready_q   <= 1'b0;
      tmds_d    <= {3{CTRL_00[0]}};
      tmds_clk  <= CLK_PATTERN[0];
      for (int ch = 0; ch < 3; ch++) begin
        sym_q[ch]  <= CTRL_00;
        disp_q[ch] <= 6'sd0;
      end
    end else begin
      bit_cnt   <= cnt_nxt;
      underflow <= underflow_nxt;
      ready_q   <= (cnt_nxt == 4'd9);
      tmds_clk  <= CLK_PATTERN[cnt_nxt];
      for (int ch = 0; ch < 3; ch++) begin
        sym_q[ch]  <= sym_nxt[ch];
        disp_q[ch] <= disp_nxt[ch];
        tmds_d[ch] <= sym_nxt[ch][cnt_nxt];
      end
    end
  end

endmodule

// File: tb/tb_tmds_serial_tx.sv
// tb_tmds_serial_tx
// Randomised self-checking bench for tmds_serial_tx. A symbol-level model
// (position within the symbol, current symbol per channel, disparity) is
// stepped on every rising edge and compared against the serial outputs on
// every falling edge; literal expectations pin the model at known points.
module tb_tmds_serial_tx;

  localparam int PHASE = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tmds_d;
  logic       tmds_clk;
  logic       underflow;

  tmds_serial_tx_if pix_bus ();

  tmds_serial_tx #(.CLK_PHASE(PHASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix       (pix_bus),
    .tmds_d    (tmds_d),
    .tmds_clk  (tmds_clk),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Model state.
  int         m_pos = 0;
  logic [9:0] m_sym [3];
  int         m_disp [3];
  bit         m_uf = 1'b0;
  int         m_accepts = 0;

  // Captured DUT symbols, one entry per completed symbol period.
  logic [9:0] cap [3];
  logic [9:0] log_sym [3][1024];
  int         sym_count = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ctrl_sym(input int c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // DVI 1.0 encoder written with integer counts.
  function automatic void model_encode(input logic [7:0] d, input int disp_in,
                                       output logic [9:0] sym, output int disp_out);
    logic [8:0] qm;
    int ones, zeros, q8;
    bit inv_chain;
    inv_chain = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv_chain ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !inv_chain;
    q8 = inv_chain ? 0 : 1;
    ones  = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (disp_in == 0 || ones == zeros) begin
      if (q8 == 1) begin
        sym = {2'b01, qm[7:0]};
        disp_out = disp_in + ones - zeros;
      end else begin
        sym = {2'b10, ~qm[7:0]};
        disp_out = disp_in + zeros - ones;
      end
    end else if ((disp_in > 0 && ones > zeros) || (disp_in < 0 && zeros > ones)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      disp_out = disp_in + 2 * q8 + zeros - ones;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      disp_out = disp_in - 2 * (1 - q8) + ones - zeros;
    end
  endfunction

  // Model: a symbol boundary follows every tenth bit.
  always @(posedge clk) begin
    logic [9:0] s;
    int         dnew;
    logic [7:0] data [3];
    if (rst) begin
      m_pos = 0;
      m_uf  = 1'b0;
      for (int n = 0; n < 3; n++) begin
        m_sym[n]  = ctrl_sym(0);
        m_disp[n] = 0;
      end
    end else if (m_pos == 9) begin
      m_pos = 0;
      if (!pix_bus.pix_valid) begin
        for (int n = 0; n < 3; n++) begin
          m_sym[n]  = ctrl_sym(0);
          m_disp[n] = 0;
        end
        m_uf = 1'b1;
      end else begin
        m_accepts++;
        if (!pix_bus.pix_de) begin
          m_sym[0] = ctrl_sym({pix_bus.pix_vsync, pix_bus.pix_hsync});
          m_sym[1] = ctrl_sym(0);
          m_sym[2] = ctrl_sym(0);
          for (int n = 0; n < 3; n++) m_disp[n] = 0;
        end else begin
          data[0] = pix_bus.pix_b;
          data[1] = pix_bus.pix_g;
          data[2] = pix_bus.pix_r;
          for (int n = 0; n < 3; n++) begin
            model_encode(data[n], m_disp[n], s, dnew);
            m_sym[n]  = s;
            m_disp[n] = dnew;
          end
        end
      end
    end else begin
      m_pos++;
    end
  end

  // Compare process: every output every cycle against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int n = 0; n < 3; n++) begin
        check_output($sformatf("tmds_d[%0d] pos %0d", n, m_pos), tmds_d[n], m_sym[n][m_pos]);
        cap[n][m_pos] = tmds_d[n];
      end
      check_output($sformatf("tmds_clk pos %0d", m_pos), tmds_clk,
                   (((m_pos - PHASE + 10) % 10) < 5) ? 1 : 0);
      check_output($sformatf("pix_ready pos %0d", m_pos), pix_bus.pix_ready, (m_pos == 9) ? 1 : 0);
      check_output("underflow", underflow, m_uf);
      if (m_pos == 9 && sym_count < 1024) begin
        for (int n = 0; n < 3; n++) log_sym[n][sym_count] = cap[n];
        sym_count++;
      end
    end
  end

  task automatic set_inputs(input bit valid, input bit de, input bit hs, input bit vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_bus.pix_valid = valid;
    pix_bus.pix_de    = de;
    pix_bus.pix_hsync = hs;
    pix_bus.pix_vsync = vs;
    pix_bus.pix_r     = r;
    pix_bus.pix_g     = g;
    pix_bus.pix_b     = b;
  endtask

  // Presents a pixel and returns just after the boundary that consumes it;
  // idx is the log slot the resulting symbol will occupy.
  task automatic apply_stimulus(input bit valid, input bit de, input bit hs, input bit vs,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                output int idx);
    bit found = 1'b0;
    set_inputs(valid, de, hs, vs, r, g, b);
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (m_pos == 9) found = 1'b1;
    end
    if (!found) check_output("slot wait timeout", 0, 1);
    @(posedge clk);
    #1;
    idx = sym_count;
  endtask

  task automatic check_log(input string name, input int idx,
                           input logic [9:0] eb, input logic [9:0] eg, input logic [9:0] er);
    int k = 0;
    while (sym_count <= idx && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (sym_count <= idx) begin
      check_output({name, " symbol timeout"}, 0, 1);
    end else begin
      check_output({name, " ch0"}, log_sym[0][idx], eb);
      check_output({name, " ch1"}, log_sym[1][idx], eg);
      check_output({name, " ch2"}, log_sym[2][idx], er);
    end
  endtask

  task automatic randomize_inputs(input int invalid_pct);
    set_inputs(($urandom_range(0, 99) >= invalid_pct), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [9:0] exp_d0;
    logic [9:0] exp_clk;
    logic [9:0] c00;
    int i_sync, i_p0, i_p1, i_p2, i_uf, i_p3, i_dummy;
    int ready_cnt, acc_before;
    bit found;

    exp_d0  = 10'b1101010100;
    exp_clk = 10'b0000011111;
    c00     = 10'b1101010100;

    rst = 1'b1;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset stream: first symbol after release, pix_valid held high.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output($sformatf("reset stream d0 bit %0d", k), tmds_d[0], exp_d0[k]);
      check_output($sformatf("reset stream clk bit %0d", k), tmds_clk, exp_clk[k]);
      check_output($sformatf("reset stream ready bit %0d", k), pix_bus.pix_ready, (k == 9) ? 1 : 0);
      check_output($sformatf("reset stream underflow bit %0d", k), underflow, 0);
    end
    @(posedge clk);
    #1;

    // Sync control, then three black pixels, underflow slot, black pixel.
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, i_sync);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, i_p0);
    for (int n = 0; n < 3; n++) check_output("model disparity after pixel 1", m_disp[n], -8);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, i_p1);
    for (int n = 0; n < 3; n++) check_output("model disparity after pixel 2", m_disp[n], 2);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, i_p2);
    for (int n = 0; n < 3; n++) check_output("model disparity after pixel 3", m_disp[n], -6);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, i_uf);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, i_p3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, i_dummy);

    check_log("sync hsync=1", i_sync, 10'b0010101011, c00, c00);
    check_log("black pixel 1", i_p0, 10'h100, 10'h100, 10'h100);
    check_log("black pixel 2", i_p1, 10'h3FF, 10'h3FF, 10'h3FF);
    check_log("black pixel 3", i_p2, 10'h100, 10'h100, 10'h100);
    check_log("underflow slot", i_uf, c00, c00, c00);
    check_log("pixel after underflow", i_p3, 10'h100, 10'h100, 10'h100);
    check_output("underflow sticky", underflow, 1);

    // Backpressure: valid held high, data changing every cycle.
    ready_cnt  = 0;
    acc_before = m_accepts;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (pix_bus.pix_ready) ready_cnt++;
      @(posedge clk);
      #1;
      randomize_inputs(0);
    end
    check_output("backpressure ready pulses", ready_cnt, 3);
    check_output("backpressure accepts", m_accepts - acc_before, 3);
    check_output("underflow still held", underflow, 1);

    // Randomised traffic with occasional missing pixels.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      randomize_inputs(10);
    end

    // Reset in the middle of a symbol.
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'h0F);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (m_pos == 4) found = 1'b1;
    end
    if (!found) check_output("mid-symbol wait timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid reset tmds_d", tmds_d, 3'b000);
    check_output("mid reset tmds_clk", tmds_clk, 1);
    check_output("mid reset pix_ready", pix_bus.pix_ready, 0);
    check_output("mid reset underflow", underflow, 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      randomize_inputs(0);
    end
    check_output("underflow clear after reset", underflow, 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tmds_serial_tx.md
TMDS_SERIAL_TX -- requirements
Module: tmds_serial_tx

Interface
REQ-001 SHALL have parameter CLK_PHASE, default 0: bit index (0-9) within each symbol at which tmds_clk's five-bit high run begins.
REQ-002 SHALL have port clk  input  1: serial bit clock; one TMDS bit per channel per cycle.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port pix_valid  input  1: pixel word present.
REQ-005 SHALL have port pix_ready  output  1: one-cycle accept strobe.
REQ-006 SHALL have port pix_r / pix_g / pix_b  input  8 each: colour data.
REQ-007 SHALL have port pix_de  input  1: active video when 1.
REQ-008 SHALL have port pix_hsync / pix_vsync  input  1 each: sync levels.
REQ-009 SHALL have port tmds_d  output  3: serial data; [0]=blue, [1]=green, [2]=red.
REQ-010 SHALL have port tmds_clk  output  1: serial TMDS clock-channel bit.
REQ-011 SHALL have port underflow  output  1: sticky flag.

Function
REQ-012 SHALL keep a bit counter bit_cnt that counts 0..9 and wraps 9->0 every cycle.
REQ-013 SHALL drive tmds_d[n] from bit bit_cnt of channel n's current 10-bit symbol: LSB first, registered, no combinational input-to-output path.
REQ-014 SHALL drive tmds_clk=1 for the 5 bit positions CLK_PHASE..CLK_PHASE+4 (mod 10) and 0 otherwise; with default CLK_PHASE=0 this is pattern 0000011111 sent LSB first.
REQ-015 SHALL assert pix_ready exactly when bit_cnt==9, independent of pix_valid.
REQ-016 SHALL accept a pixel when pix_valid && pix_ready; its encoded symbols are output starting the next cycle at bit_cnt=0, so latency is 1 cycle from accept to first bit.
REQ-017 SHALL ignore pix_valid when pix_ready=0; inputs are not consumed.
REQ-018 On accept with pix_de=0, SHALL load control symbols: ch0 uses c1c0={vsync,hsync}, ch1 and ch2 use c=00.
REQ-019 On accept with pix_de=0, SHALL reset all disparity counters to 0.
REQ-020 SHALL use the control symbol table (bit9..bit0): 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
REQ-021 On accept with pix_de=1, SHALL apply DVI 1.0 8b/10b encoding per channel.
REQ-022 8b/10b stage 1: q_m uses XNOR chaining if n1(D)>4, or if n1(D)==4 and D[0]==0; otherwise XOR chaining. q_m[8]=1 for XOR, 0 for XNOR.
REQ-023 8b/10b stage 2: follow the DVI DC-balance rules using a per-channel signed disparity counter of at least 5 bits, updated only on data-symbol loads.
REQ-024 At bit_cnt==9 with pix_valid=0, SHALL load control symbol c=00 on all channels, reset disparity to 0, and set underflow=1.
REQ-025 underflow SHALL stay set until rst.
REQ-026 SHALL hold the sync level for underflow-inserted symbols at 0 on ch0.

Reset
REQ-027 rst SHALL be sampled on the clk edge only, and SHALL take effect from any state, including mid-symbol.
REQ-028 Reset SHALL give: bit_cnt=0, all channel symbols=1101010100, disparity=0, underflow=0.
REQ-029 Reset SHALL give outputs: tmds_d=3'b000, tmds_clk=1 (CLK_PHASE=0), pix_ready=0.
REQ-030 After rst deasserts, the first pix_ready SHALL occur on the 10th cycle (bit_cnt==9), then every 10 cycles.

Verification
REQ-031 Reset check: hold rst 3 cycles, then release -> tmds_d[0] serial stream 0,0,1,0,1,0,1,0,1,1; tmds_clk 1,1,1,1,1,0,0,0,0,0; pix_ready high only at cycle 9; underflow=0 with pix_valid held 1.
REQ-032 Sync control: accept de=0, hsync=1, vsync=0 -> ch0 symbol 0010101011; ch1 and ch2 symbols 1101010100.
REQ-033 Disparity: after a control symbol, accept three pixels with r=g=b=0x00, de=1 -> each channel emits 0x100, 0x3FF, 0x100; disparity goes -8, +2, -6.
REQ-034 Underflow: drop pix_valid for one pix_ready slot mid-stream -> c=00 symbols on all channels, underflow=1 and held; the next valid pixel is encoded from disparity 0.
REQ-035 Backpressure: hold pix_valid high with changing data for 30 cycles -> exactly 3 accepts, one per pix_ready, each using the data present on its ready cycle.
REQ-036 Reset mid-symbol: assert rst at bit_cnt=4 -> next cycle bit_cnt=0, reset symbols loaded, underflow cleared, tmds_clk=1.
